// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light controller and its phase timer.
// Lamp buses are packed per lane, indexed by the lane number.
package tlc_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_FAULT  = 2'b11
  } phase_e;

  localparam logic [1:0] LANE_W = 2'd0;
  localparam logic [1:0] LANE_S = 2'd1;
  localparam logic [1:0] LANE_E = 2'd2;
  localparam logic [1:0] LANE_N = 2'd3;

  localparam int LAMP_RED    = 2;
  localparam int LAMP_YELLOW = 1;
  localparam int LAMP_GREEN  = 0;

  typedef logic [3:0][2:0] lamp_bus_t;
  typedef logic [3:0][1:0] sensor_bus_t;

endpackage

// File: rtl/tlc_lamp_decode.sv
// Combinational decode of the four lamp groups: single green/yellow lane
// detection and illegal-combination flag.
module tlc_lamp_decode
  import tlc_pkg::*;
(
  input  lamp_bus_t  i_lamps,
  output logic       o_one_green,
  output logic [1:0] o_green_lane,
  output logic       o_one_yellow,
  output logic [1:0] o_yellow_lane,
  output logic       o_illegal
);

  logic [2:0] w_g_cnt;
  logic [2:0] w_y_cnt;
  logic       w_multi;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_g_cnt       = '0;
    w_y_cnt       = '0;
    w_multi       = 1'b0;
    o_green_lane  = '0;
    o_yellow_lane = '0;
    for (int i = 0; i < 4; i++) begin
      if (i_lamps[i][LAMP_GREEN]) begin
        w_g_cnt      = w_g_cnt + 3'd1;
        o_green_lane = 2'(i);
      end
      if (i_lamps[i][LAMP_YELLOW]) begin
        w_y_cnt       = w_y_cnt + 3'd1;
        o_yellow_lane = 2'(i);
      end
      if ($countones(i_lamps[i]) > 1) w_multi = 1'b1;
    end
    o_one_green  = (w_g_cnt == 3'd1);
    o_one_yellow = (w_y_cnt == 3'd1);
    // Total green+yellow above one also covers two greens or two yellows.
    o_illegal    = w_multi || (({1'b0, w_g_cnt} + {1'b0, w_y_cnt}) > 4'd1);
  end

endmodule

// File: rtl/tlc_phase_timer.sv
// Phase timer for tlc: tracks the active green/yellow phase from the lamps and
// raises the expiry strobes tlc waits on. Illegal lamp patterns latch FAULT.
module tlc_phase_timer
  import tlc_pkg::*;
#(
  parameter int G2Y_CYCLES = 30,
  parameter int Y2R_CYCLES = 10,
  parameter int EXT_STEP   = 5,
  parameter int CNT_W      = 8
) (
  input  logic       i_clock,
  input  logic       i_reset_b,
  input  logic [2:0] i_w_lamp,
  input  logic [2:0] i_s_lamp,
  input  logic [2:0] i_e_lamp,
  input  logic [2:0] i_n_lamp,
  input  logic [1:0] i_w_sensor,
  input  logic [1:0] i_s_sensor,
  input  logic [1:0] i_e_sensor,
  input  logic [1:0] i_n_sensor,
  output logic       o_g2y_timer,
  output logic       o_y2r_timer,
  output logic [1:0] o_phase,
  output logic [1:0] o_lane,
  output logic       o_fault
);

  localparam logic [CNT_W-1:0] Y2R_T = CNT_W'(Y2R_CYCLES);

  lamp_bus_t   w_lamps;
  sensor_bus_t w_sensors;
  logic        w_one_green, w_one_yellow, w_illegal;
  logic [1:0]  w_green_lane, w_yellow_lane;
  logic [CNT_W-1:0] w_green_target, w_cnt_inc;

  phase_e           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic [CNT_W-1:0] r_target, w_next_target;
  logic [1:0]       r_lane, w_next_lane;

  assign w_lamps   = {i_n_lamp, i_e_lamp, i_s_lamp, i_w_lamp};
  assign w_sensors = {i_n_sensor, i_e_sensor, i_s_sensor, i_w_sensor};

  tlc_lamp_decode u_decode (
    .i_lamps       (w_lamps),
    .o_one_green   (w_one_green),
    .o_green_lane  (w_green_lane),
    .o_one_yellow  (w_one_yellow),
    .o_yellow_lane (w_yellow_lane),
    .o_illegal     (w_illegal)
  );

  // Sensor is only consumed at green entry, so later changes cannot stretch a phase.
  assign w_green_target = CNT_W'(G2Y_CYCLES)
                        + CNT_W'(EXT_STEP) * CNT_W'(w_sensors[w_green_lane]);
  assign w_cnt_inc      = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_target = r_target;
    w_next_lane   = r_lane;
    if (w_illegal || r_state == PH_FAULT) begin
      w_next_state = PH_FAULT;
    end else if (w_one_green) begin
      w_next_state = PH_GREEN;
      if (r_state == PH_GREEN && w_green_lane == r_lane) begin
        w_next_cnt = w_cnt_inc;
      end else begin
        w_next_cnt    = CNT_W'(1);
        w_next_lane   = w_green_lane;
        w_next_target = w_green_target;
      end
    end else if (w_one_yellow) begin
      w_next_state = PH_YELLOW;
      if (r_state == PH_YELLOW && w_yellow_lane == r_lane) begin
        w_next_cnt = w_cnt_inc;
      end else begin
        w_next_cnt    = CNT_W'(1);
        w_next_lane   = w_yellow_lane;
        w_next_target = Y2R_T;
      end
    end else begin
      w_next_state = PH_IDLE;
      w_next_cnt   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset_b) begin
    if (i_reset_b) begin
      r_state  <= PH_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_lane   <= '0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_target <= w_next_target;
      r_lane   <= w_next_lane;
    end
  end

  assign o_phase     = r_state;
  assign o_lane      = (r_state == PH_GREEN || r_state == PH_YELLOW) ? r_lane : 2'd0;
  assign o_fault     = (r_state == PH_FAULT);
  assign o_g2y_timer = (r_state == PH_GREEN)  && (r_cnt >= r_target);
  assign o_y2r_timer = (r_state == PH_YELLOW) && (r_cnt >= r_target);

endmodule

// File: tb/tb_tlc_phase_timer.sv
// Directed bench for tlc_phase_timer: expiry timing, sensor extension, lane
// restart, fault latch and asynchronous reset, plus a T=1 instance.
module tb_tlc_phase_timer;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] w_lamp = RED, s_lamp = RED, e_lamp = RED, n_lamp = RED;
  logic [1:0] w_sen = 2'd0, s_sen = 2'd0, e_sen = 2'd0, n_sen = 2'd0;

  logic       g2y, y2r, fault;
  logic [1:0] phase, lane;
  logic       t1_g2y, t1_y2r, t1_fault;
  logic [1:0] t1_phase, t1_lane;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlc_phase_timer dut (
    .i_clock(clk), .i_reset_b(rst),
    .i_w_lamp(w_lamp), .i_s_lamp(s_lamp), .i_e_lamp(e_lamp), .i_n_lamp(n_lamp),
    .i_w_sensor(w_sen), .i_s_sensor(s_sen), .i_e_sensor(e_sen), .i_n_sensor(n_sen),
    .o_g2y_timer(g2y), .o_y2r_timer(y2r), .o_phase(phase), .o_lane(lane), .o_fault(fault)
  );

  tlc_phase_timer #(.G2Y_CYCLES(1), .Y2R_CYCLES(1), .EXT_STEP(0), .CNT_W(8)) dut_t1 (
    .i_clock(clk), .i_reset_b(rst),
    .i_w_lamp(w_lamp), .i_s_lamp(s_lamp), .i_e_lamp(e_lamp), .i_n_lamp(n_lamp),
    .i_w_sensor(w_sen), .i_s_sensor(s_sen), .i_e_sensor(e_sen), .i_n_sensor(n_sen),
    .o_g2y_timer(t1_g2y), .o_y2r_timer(t1_y2r), .o_phase(t1_phase), .o_lane(t1_lane),
    .o_fault(t1_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic [2:0] w, input logic [2:0] s,
                           input logic [2:0] e, input logic [2:0] n);
    w_lamp = w; s_lamp = s; e_lamp = e; n_lamp = n;
  endtask

  task automatic test_reset();
    #20;
    checks++;
    if ({phase, lane, g2y, y2r, fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_held: phase=%b lane=%0d g2y=%b y2r=%b fault=%b, expected all 0",
               phase, lane, g2y, y2r, fault);
    end
    #30 rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (phase !== 2'b00 || g2y !== 1'b0 || y2r !== 1'b0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL idle_all_red cycle %0d: phase=%b g2y=%b y2r=%b fault=%b, expected 00/0/0/0",
                 c, phase, g2y, y2r, fault);
      end
    end
  endtask

  task automatic test_green_west();
    logic exp;
    set_lamps(GRN, RED, RED, RED);
    tick();
    checks++;
    if (phase !== 2'b01 || lane !== 2'd0 || g2y !== 1'b0) begin
      errors++;
      $display("FAIL west_entry: phase=%b lane=%0d g2y=%b, expected 01/0/0", phase, lane, g2y);
    end
    checks++;
    if (t1_g2y !== 1'b1) begin
      errors++;
      $display("FAIL t1_green_entry: g2y=%b, expected 1", t1_g2y);
    end
    for (int j = 1; j <= 34; j++) begin
      tick();
      exp = (j >= 29);
      checks++;
      if (g2y !== exp) begin
        errors++;
        $display("FAIL west_g2y edge k+%0d: got %b, expected %b", j, g2y, exp);
      end
    end
    set_lamps(YEL, RED, RED, RED);
    tick();
    checks++;
    if (phase !== 2'b10 || lane !== 2'd0 || g2y !== 1'b0 || y2r !== 1'b0) begin
      errors++;
      $display("FAIL west_yellow_entry: phase=%b lane=%0d g2y=%b y2r=%b, expected 10/0/0/0",
               phase, lane, g2y, y2r);
    end
    checks++;
    if (t1_y2r !== 1'b1) begin
      errors++;
      $display("FAIL t1_yellow_entry: y2r=%b, expected 1", t1_y2r);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp = (j >= 9);
      checks++;
      if (y2r !== exp) begin
        errors++;
        $display("FAIL west_y2r edge y+%0d: got %b, expected %b", j, y2r, exp);
      end
    end
    set_lamps(DARK, DARK, DARK, DARK);
    tick();
    checks++;
    if (phase !== 2'b00 || y2r !== 1'b0 || fault !== 1'b0 || lane !== 2'd0) begin
      errors++;
      $display("FAIL all_dark_idle: phase=%b y2r=%b fault=%b lane=%0d, expected 00/0/0/0",
               phase, y2r, fault, lane);
    end
  endtask

  task automatic test_sensor_ext();
    logic exp;
    n_sen = 2'd3;
    set_lamps(RED, RED, RED, GRN);
    tick();
    checks++;
    if (phase !== 2'b01 || lane !== 2'd3) begin
      errors++;
      $display("FAIL north_entry: phase=%b lane=%0d, expected 01/3", phase, lane);
    end
    for (int j = 1; j <= 46; j++) begin
      if (j == 5) n_sen = 2'd0;
      tick();
      exp = (j >= 44);
      checks++;
      if (g2y !== exp) begin
        errors++;
        $display("FAIL north_ext_g2y edge k+%0d: got %b, expected %b", j, g2y, exp);
      end
    end
    set_lamps(RED, RED, RED, RED);
    tick();
  endtask

  task automatic test_lane_switch();
    logic exp;
    set_lamps(GRN, RED, RED, RED);
    tick();
    repeat (19) tick();
    checks++;
    if (g2y !== 1'b0 || lane !== 2'd0) begin
      errors++;
      $display("FAIL west_20_cycles: g2y=%b lane=%0d, expected 0/0", g2y, lane);
    end
    set_lamps(RED, GRN, RED, RED);
    tick();
    checks++;
    if (phase !== 2'b01 || lane !== 2'd1 || g2y !== 1'b0) begin
      errors++;
      $display("FAIL south_switch: phase=%b lane=%0d g2y=%b, expected 01/1/0", phase, lane, g2y);
    end
    for (int j = 1; j <= 31; j++) begin
      tick();
      exp = (j >= 29);
      checks++;
      if (g2y !== exp) begin
        errors++;
        $display("FAIL south_g2y edge s+%0d: got %b, expected %b", j, g2y, exp);
      end
    end
    set_lamps(RED, RED, RED, RED);
    tick();
  endtask

  task automatic test_fault();
    set_lamps(GRN, RED, GRN, RED);
    tick();
    checks++;
    if (fault !== 1'b1 || phase !== 2'b11 || lane !== 2'd0 || g2y !== 1'b0 || y2r !== 1'b0) begin
      errors++;
      $display("FAIL fault_entry: fault=%b phase=%b lane=%0d g2y=%b y2r=%b, expected 1/11/0/0/0",
               fault, phase, lane, g2y, y2r);
    end
    set_lamps(GRN, RED, RED, RED);
    for (int j = 1; j <= 40; j++) begin
      tick();
      checks++;
      if (fault !== 1'b1 || phase !== 2'b11 || g2y !== 1'b0 || y2r !== 1'b0) begin
        errors++;
        $display("FAIL fault_sticky cycle %0d: fault=%b phase=%b g2y=%b y2r=%b, expected 1/11/0/0",
                 j, fault, phase, g2y, y2r);
      end
    end
    set_lamps(RED, RED, RED, RED);
    rst = 1'b1;
    #2;
    checks++;
    if (fault !== 1'b0 || phase !== 2'b00) begin
      errors++;
      $display("FAIL fault_cleared_by_reset: fault=%b phase=%b, expected 0/00", fault, phase);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_yellow_reset();
    logic exp;
    set_lamps(YEL, RED, RED, RED);
    tick();
    repeat (5) tick();
    checks++;
    if (phase !== 2'b10 || y2r !== 1'b0) begin
      errors++;
      $display("FAIL yellow_cycle6: phase=%b y2r=%b, expected 10/0", phase, y2r);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({phase, lane, g2y, y2r, fault} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: phase=%b lane=%0d g2y=%b y2r=%b fault=%b, expected all 0",
               phase, lane, g2y, y2r, fault);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (phase !== 2'b10 || y2r !== 1'b0) begin
      errors++;
      $display("FAIL yellow_reentry: phase=%b y2r=%b, expected 10/0", phase, y2r);
    end
    for (int j = 1; j <= 11; j++) begin
      tick();
      exp = (j >= 9);
      checks++;
      if (y2r !== exp) begin
        errors++;
        $display("FAIL yellow_after_reset edge +%0d: got %b, expected %b", j, y2r, exp);
      end
    end
    set_lamps(RED, RED, RED, RED);
    tick();
  endtask

  initial begin
    test_reset();
    test_green_west();
    test_sensor_ext();
    test_lane_switch();
    test_fault();
    test_yellow_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
